traffic_phase_sequencer: RTL and testbench

Parametrised successor to the fixed six-state intersection controller. It sequences NUM_PHASES signal groups through green → yellow → all-red clearance in round-robin order. Phase durations are runtime-programmable in units of an external `tick` strobe. The block adds a latched pedestrian-walk insertion and a flashing-yellow override. It sits between the seconds prescaler and the lamp-driver outputs.

---
 rtl/tlc_pkg.sv | 33 +++
 rtl/tick_counter.sv | 41 ++++
 rtl/traffic_phase_sequencer.sv | 124 ++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic phase sequencer: controller states,
// lamp encodings, power-on duration defaults and the per-phase lamp decode.
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_ALLRED = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_WALK   = 3'd3,
        ST_FLASH  = 3'd4
    } state_t;

    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [2:0] LT_DARK   = 3'b000;

    localparam int DEF_GREEN_TIME  = 20;
    localparam int DEF_YELLOW_TIME = 3;
    localparam int DEF_ALLRED_TIME = 2;
    localparam int DEF_WALK_TIME   = 10;

    // sel marks the phase currently served; tog is the flash blink phase.
    function automatic logic [2:0] lamp_code(state_t st, logic sel, logic tog);
        case (st)
            ST_GREEN:  return sel ? LT_GREEN : LT_RED;
            ST_YELLOW: return sel ? LT_YELLOW : LT_RED;
            ST_FLASH:  return tog ? LT_DARK : LT_YELLOW;
            default:   return LT_RED;
        endcase
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Duration counter: counts tick strobes and flags the last tick of a state that
// lasts max(dur,1) ticks. The target is captured on the first cycle of each state.
module tick_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             entry,
    input  logic [CNT_W-1:0] dur,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] target_reg;
    logic [CNT_W-1:0] target_live;
    logic [CNT_W-1:0] target_eff;

    assign target_live = (dur == '0) ? CNT_W'(1) : dur;
    // On the entry cycle the register has not captured yet, so use the live value.
    assign target_eff  = entry ? target_live : target_reg;
    assign done        = en && (count_reg == target_eff - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            target_reg <= CNT_W'(1);
        end else begin
            if (entry) begin
                target_reg <= target_live;
            end
            if (clr) begin
                count_reg <= '0;
            end else if (en) begin
                count_reg <= done ? '0 : count_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Round-robin intersection controller: green/yellow/all-red per phase, latched
// pedestrian walk insertion after all-red, and a flashing-yellow override.
import tlc_pkg::*;

module traffic_phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 8,
    parameter int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic [NUM_PHASES*CNT_W-1:0] green_time,
    input  logic [CNT_W-1:0]            yellow_time,
    input  logic [CNT_W-1:0]            allred_time,
    input  logic [CNT_W-1:0]            walk_time,
    input  logic                        ped_req,
    input  logic                        flash_mode,
    output logic [NUM_PHASES*3-1:0]     lights,
    output logic [PH_W-1:0]             cur_phase,
    output logic                        ped_walk,
    output logic                        ped_ack
);

    state_t          state_reg, state_next;
    logic [PH_W-1:0] phase_reg, phase_next, phase_inc;
    logic            ped_pending_reg, ped_pending_next;
    logic            ped_ack_reg, ped_ack_next;
    logic            flash_tog_reg, flash_tog_next;
    logic            entry_reg;
    logic            cnt_done, cnt_clr;
    logic [CNT_W-1:0] dur_cur;
    logic [CNT_W-1:0] green_arr [NUM_PHASES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
            assign green_arr[gi]       = green_time[gi*CNT_W +: CNT_W];
            assign lights[gi*3 +: 3]   = lamp_code(state_reg, phase_reg == PH_W'(gi), flash_tog_reg);
        end
    endgenerate

    assign phase_inc = (phase_reg == PH_W'(NUM_PHASES-1)) ? '0 : phase_reg + 1'b1;
    // Any tick in or into flash restarts the duration count.
    assign cnt_clr   = tick && (flash_mode || state_reg == ST_FLASH);

    always_comb begin
        dur_cur = allred_time;
        case (state_reg)
            ST_GREEN:  dur_cur = green_arr[phase_reg];
            ST_YELLOW: dur_cur = yellow_time;
            ST_WALK:   dur_cur = walk_time;
            default:   ;
        endcase
    end

    tick_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick),
        .clr   (cnt_clr),
        .entry (entry_reg),
        .dur   (dur_cur),
        .done  (cnt_done)
    );

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        flash_tog_next = flash_tog_reg;
        ped_ack_next   = 1'b0;
        if (tick && flash_mode) begin
            state_next     = ST_FLASH;
            flash_tog_next = (state_reg == ST_FLASH) ? ~flash_tog_reg : 1'b0;
        end else if (tick && state_reg == ST_FLASH) begin
            state_next     = ST_ALLRED;
            flash_tog_next = 1'b0;
        end else if (cnt_done) begin
            case (state_reg)
                ST_GREEN:  state_next = ST_YELLOW;
                ST_YELLOW: state_next = ST_ALLRED;
                ST_ALLRED: begin
                    if (ped_pending_reg) begin
                        state_next   = ST_WALK;
                        ped_ack_next = 1'b1;
                    end else begin
                        state_next = ST_GREEN;
                        phase_next = phase_inc;
                    end
                end
                ST_WALK: begin
                    state_next = ST_GREEN;
                    phase_next = phase_inc;
                end
                default: ;
            endcase
        end
        // A request arriving on the walk-entry edge survives the clear.
        ped_pending_next = ped_req | (ped_pending_reg & ~ped_ack_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_ALLRED;
            phase_reg       <= PH_W'(NUM_PHASES-1);
            ped_pending_reg <= 1'b0;
            ped_ack_reg     <= 1'b0;
            flash_tog_reg   <= 1'b0;
            entry_reg       <= 1'b1;
        end else begin
            state_reg       <= state_next;
            phase_reg       <= phase_next;
            ped_pending_reg <= ped_pending_next;
            ped_ack_reg     <= ped_ack_next;
            flash_tog_reg   <= flash_tog_next;
            entry_reg       <= (state_next != state_reg) || cnt_clr;
        end
    end

    assign cur_phase = phase_reg;
    assign ped_walk  = (state_reg == ST_WALK);
    assign ped_ack   = ped_ack_reg;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench: each scenario queues the expected sequence of output segments
// (lights, phase, walk, length in clocks); a monitor pops one per output change.
module tb_traffic_phase_sequencer;

    localparam int NP = 4;
    localparam int CW = 8;
    localparam int PW = 2;
    localparam int K_R = 0, K_G = 1, K_Y = 2, K_W = 3, K_F = 4, K_D = 5;
    localparam logic [NP*3-1:0] ALL_RED = 12'b100100100100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic ped_req = 1'b0;
    logic flash_mode = 1'b0;
    logic [NP*CW-1:0] green_time = '0;
    logic [CW-1:0] yellow_time = '0, allred_time = '0, walk_time = '0;
    logic [NP*3-1:0] lights;
    logic [PW-1:0] cur_phase;
    logic ped_walk, ped_ack;

    typedef struct {
        logic [NP*3-1:0] lt;
        logic [PW-1:0]   ph;
        logic            walk;
        int              len;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int ack_cnt = 0;
    bit mon_en = 1'b0;

    traffic_phase_sequencer #(.NUM_PHASES(NP), .CNT_W(CW), .PH_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .green_time  (green_time),
        .yellow_time (yellow_time),
        .allred_time (allred_time),
        .walk_time   (walk_time),
        .ped_req     (ped_req),
        .flash_mode  (flash_mode),
        .lights      (lights),
        .cur_phase   (cur_phase),
        .ped_walk    (ped_walk),
        .ped_ack     (ped_ack)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(int kind, int ph, int len);
        exp_t e;
        logic [2:0] c;
        e.ph   = PW'(ph);
        e.walk = (kind == K_W);
        e.len  = len;
        e.lt   = '0;
        for (int p = 0; p < NP; p++) begin
            case (kind)
                K_G:     c = (p == ph) ? 3'b001 : 3'b100;
                K_Y:     c = (p == ph) ? 3'b010 : 3'b100;
                K_F:     c = 3'b010;
                K_D:     c = 3'b000;
                default: c = 3'b100;
            endcase
            e.lt[p*3 +: 3] = c;
        end
        return e;
    endfunction

    task automatic push(int kind, int ph, int len);
        sb.push_back(mk(kind, ph, len));
    endtask

    // Monitor: one sample per clock, 1 time unit after the rising edge.
    initial begin : monitor
        logic [NP*3+PW:0] prev, obs;
        bit have;
        bit new_seg;
        int cnt;
        exp_t cur;
        have = 1'b0;
        cnt = 0;
        prev = '0;
        cur = mk(K_R, 0, 0);
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en) begin
                have = 1'b0;
                continue;
            end
            obs = {lights, cur_phase, ped_walk};
            new_seg = (!have || obs !== prev);
            if (new_seg) begin
                if (have && cur.len != 0) check("seg_len", cnt, cur.len);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL seg_unexpected: actual lights=%b phase=%0d walk=%b required=no change",
                             lights, cur_phase, ped_walk);
                    cur = mk(K_R, 0, 0);
                end else begin
                    cur = sb.pop_front();
                    check("seg_lights", 32'(lights), 32'(cur.lt));
                    check("seg_phase", 32'(cur_phase), 32'(cur.ph));
                    check("seg_walk", 32'(ped_walk), 32'(cur.walk));
                end
                prev = obs;
                have = 1'b1;
                cnt = 1;
            end else begin
                cnt++;
            end
            check("ped_ack", 32'(ped_ack), 32'(new_seg && cur.walk));
            if (ped_ack) ack_cnt++;
        end
    end

    task automatic start_scn(int g0, int g1, int g2, int g3, int y, int ar, int w);
        @(negedge clk);
        rst_n = 1'b0;
        mon_en = 1'b0;
        tick = 1'b0;
        ped_req = 1'b0;
        flash_mode = 1'b0;
        green_time = {CW'(g3), CW'(g2), CW'(g1), CW'(g0)};
        yellow_time = CW'(y);
        allred_time = CW'(ar);
        walk_time = CW'(w);
        @(negedge clk);
        sb.delete();
        ack_cnt = 0;
        check("rst_lights", 32'(lights), 32'(ALL_RED));
        check("rst_phase", 32'(cur_phase), 32'(NP-1));
        check("rst_walk", 32'(ped_walk), 32'(0));
        check("rst_ack", 32'(ped_ack), 32'(0));
    endtask

    task automatic run_scn(int scn, int exp_acks);
        int i;
        mon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        i = 0;
        forever begin
            tick = (scn == 2) ? (i % 3 == 0) : 1'b1;
            ped_req = (scn == 3 && (i == 14 || i == 16)) || (scn == 5 && i == 21) || (scn == 6 && i == 9);
            flash_mode = (scn == 4 && i >= 9 && i <= 13) || (scn == 6 && i >= 9 && i <= 11);
            if (scn == 5 && i == 24) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_lights", 32'(lights), 32'(ALL_RED));
                check("async_rst_walk", 32'(ped_walk), 32'(0));
            end
            if (scn == 5 && i == 27) rst_n = 1'b1;
            @(negedge clk);
            i++;
            if (sb.size() == 0 || i >= 300) break;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scn%0d_timeout: actual=%0d segments pending required=0", scn, sb.size());
        end
        mon_en = 1'b0;
        check("ped_ack_count", ack_cnt, exp_acks);
    endtask

    initial begin
        // 1: basic rotation, green p0..p3 = 5,2,3,4, yellow 2, allred 1 (26-clock cycle)
        start_scn(5, 2, 3, 4, 2, 1, 3);
        push(K_R, 3, 0);
        push(K_G, 0, 5); push(K_Y, 0, 2); push(K_R, 0, 1);
        push(K_G, 1, 2); push(K_Y, 1, 2); push(K_R, 1, 1);
        push(K_G, 2, 3); push(K_Y, 2, 2); push(K_R, 2, 1);
        push(K_G, 3, 4); push(K_Y, 3, 2); push(K_R, 3, 1);
        push(K_G, 0, 0);
        run_scn(1, 0);

        // 2: zero green on phase 1, tick every 3rd clock
        start_scn(2, 0, 1, 1, 1, 1, 3);
        push(K_R, 3, 0);
        push(K_G, 0, 6); push(K_Y, 0, 3); push(K_R, 0, 3);
        push(K_G, 1, 3); push(K_Y, 1, 3); push(K_R, 1, 3);
        push(K_G, 2, 3); push(K_Y, 2, 3); push(K_R, 2, 3);
        push(K_G, 3, 0);
        run_scn(2, 0);

        // 3: two ped requests during GREEN(2) give a single walk before GREEN(3)
        start_scn(5, 2, 3, 4, 2, 1, 3);
        push(K_R, 3, 0);
        push(K_G, 0, 5); push(K_Y, 0, 2); push(K_R, 0, 1);
        push(K_G, 1, 2); push(K_Y, 1, 2); push(K_R, 1, 1);
        push(K_G, 2, 3); push(K_Y, 2, 2); push(K_R, 2, 1);
        push(K_W, 2, 3);
        push(K_G, 3, 4); push(K_Y, 3, 2); push(K_R, 3, 1);
        push(K_G, 0, 0);
        run_scn(3, 1);

        // 4: flash raised mid-GREEN(1), then all-red and GREEN(2)
        start_scn(5, 2, 3, 4, 2, 1, 3);
        push(K_R, 3, 0);
        push(K_G, 0, 5); push(K_Y, 0, 2); push(K_R, 0, 1);
        push(K_G, 1, 1);
        push(K_F, 1, 1); push(K_D, 1, 1); push(K_F, 1, 1); push(K_D, 1, 1); push(K_F, 1, 1);
        push(K_R, 1, 1);
        push(K_G, 2, 3); push(K_Y, 2, 0);
        run_scn(4, 0);

        // 5: async reset mid-YELLOW(3) drops the pending ped request
        start_scn(5, 2, 3, 4, 2, 1, 3);
        push(K_R, 3, 0);
        push(K_G, 0, 5); push(K_Y, 0, 2); push(K_R, 0, 1);
        push(K_G, 1, 2); push(K_Y, 1, 2); push(K_R, 1, 1);
        push(K_G, 2, 3); push(K_Y, 2, 2); push(K_R, 2, 1);
        push(K_G, 3, 4); push(K_Y, 3, 0);
        push(K_R, 3, 3);
        push(K_G, 0, 5); push(K_Y, 0, 2); push(K_R, 0, 1);
        push(K_G, 1, 0);
        run_scn(5, 0);

        // 6: ped request on the flash-entry cycle is served after flash exit
        start_scn(5, 2, 3, 4, 2, 1, 3);
        push(K_R, 3, 0);
        push(K_G, 0, 5); push(K_Y, 0, 2); push(K_R, 0, 1);
        push(K_G, 1, 1);
        push(K_F, 1, 1); push(K_D, 1, 1); push(K_F, 1, 1);
        push(K_R, 1, 1);
        push(K_W, 1, 3);
        push(K_G, 2, 3); push(K_Y, 2, 0);
        run_scn(6, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1);
    end

endmodule
